// File: rtl/nx_stat_counter_bank.sv
// Bank of saturating event counters with a coherent snapshot array for the
// downstream read-only register array. Two-stage: S1 registers requests, S2 updates.

module nx_stat_counter_lane #(
  parameter int N_DATA_BITS = 64,
  parameter int N_INC_BITS  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inc,
  input  logic [N_INC_BITS-1:0]  amt,
  input  logic                   clr,
  input  logic                   snap,
  output logic [N_DATA_BITS-1:0] snap_val,
  output logic                   sat_evt
);
  logic [N_DATA_BITS-1:0] cnt, base, nxt;
  logic [N_DATA_BITS:0]   sum;

  // Clear acts on the old value; an increment in the same cycle lands on zero.
  always_comb begin
    base    = clr ? '0 : cnt;
    sum     = {1'b0, base} + {{(N_DATA_BITS+1-N_INC_BITS){1'b0}}, amt};
    sat_evt = inc & sum[N_DATA_BITS];
    if (!inc)                 nxt = base;
    else if (sum[N_DATA_BITS]) nxt = '1;
    else                      nxt = sum[N_DATA_BITS-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      snap_val <= '0;
    end else begin
      cnt <= nxt;
      if (snap) snap_val <= nxt;
    end
  end
endmodule

module nx_stat_counter_bank #(
  parameter int N_ENTRIES   = 32,
  parameter int N_DATA_BITS = 64,
  parameter int N_INC_BITS  = 16,
  localparam int IDX_W      = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   inc_vld,
  input  logic [IDX_W-1:0]                       inc_idx,
  input  logic [N_INC_BITS-1:0]                  inc_amt,
  input  logic                                   clr_stb,
  input  logic [IDX_W-1:0]                       clr_idx,
  input  logic                                   clr_all,
  input  logic                                   snap_stb,
  output logic [0:N_ENTRIES-1][N_DATA_BITS-1:0]  mem_a,
  output logic                                   snap_done,
  output logic                                   sat_any,
  output logic                                   err_idx
);
  localparam int IDX_N = 1 << IDX_W;
  // One bit per encodable index: set where the index names a real counter.
  localparam logic [IDX_N-1:0] IDX_OK = {IDX_N{1'b1}} >> (IDX_N - N_ENTRIES);

  logic                  s1_inc_vld, s1_clr_stb, s1_clr_all, s1_snap;
  logic [IDX_W-1:0]      s1_inc_idx, s1_clr_idx;
  logic [N_INC_BITS-1:0] s1_inc_amt;
  logic                  inc_ok, clr_ok, sat_hit;
  logic [N_ENTRIES-1:0]  sat_evt;

  assign inc_ok  = IDX_OK[s1_inc_idx];
  assign clr_ok  = IDX_OK[s1_clr_idx];
  assign sat_hit = |sat_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_inc_vld <= 1'b0;
      s1_inc_idx <= '0;
      s1_inc_amt <= '0;
      s1_clr_stb <= 1'b0;
      s1_clr_idx <= '0;
      s1_clr_all <= 1'b0;
      s1_snap    <= 1'b0;
      snap_done  <= 1'b0;
      sat_any    <= 1'b0;
      err_idx    <= 1'b0;
    end else begin
      s1_inc_vld <= inc_vld;
      s1_inc_idx <= inc_idx;
      s1_inc_amt <= inc_amt;
      s1_clr_stb <= clr_stb;
      s1_clr_idx <= clr_idx;
      s1_clr_all <= clr_all;
      s1_snap    <= snap_stb;
      snap_done  <= s1_snap;
      err_idx    <= (s1_inc_vld & ~inc_ok) | (s1_clr_stb & ~clr_ok);
      // clr_all restarts the sticky flag, but a saturation in that same update still counts.
      if (s1_clr_all)   sat_any <= sat_hit;
      else if (sat_hit) sat_any <= 1'b1;
    end
  end

  for (genvar i = 0; i < N_ENTRIES; i++) begin : g_lane
    nx_stat_counter_lane #(
      .N_DATA_BITS (N_DATA_BITS),
      .N_INC_BITS  (N_INC_BITS)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (s1_inc_vld & inc_ok & (s1_inc_idx == IDX_W'(i))),
      .amt      (s1_inc_amt),
      .clr      (s1_clr_all | (s1_clr_stb & clr_ok & (s1_clr_idx == IDX_W'(i)))),
      .snap     (s1_snap),
      .snap_val (mem_a[i]),
      .sat_evt  (sat_evt[i])
    );
  end
endmodule

// File: tb/tb_nx_stat_counter_bank.sv
// Directed bench: full-width bank for the main paths, a 20-bit bank on the
// same stimulus so saturation is reachable with 16-bit increments.
module tb_nx_stat_counter_bank;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        inc_vld, clr_stb, clr_all, snap_stb;
  logic [4:0]  inc_idx, clr_idx;
  logic [15:0] inc_amt;

  logic [0:31][63:0] mem_a;
  logic              snap_done, sat_any, err_idx;
  logic [0:31][19:0] n_mem;
  logic              n_done, n_sat, n_err_idx;

  nx_stat_counter_bank dut (
    .clk(clk), .rst_n(rst_n), .inc_vld(inc_vld), .inc_idx(inc_idx), .inc_amt(inc_amt),
    .clr_stb(clr_stb), .clr_idx(clr_idx), .clr_all(clr_all), .snap_stb(snap_stb),
    .mem_a(mem_a), .snap_done(snap_done), .sat_any(sat_any), .err_idx(err_idx)
  );

  nx_stat_counter_bank #(.N_ENTRIES(32), .N_DATA_BITS(20), .N_INC_BITS(16)) dut_n (
    .clk(clk), .rst_n(rst_n), .inc_vld(inc_vld), .inc_idx(inc_idx), .inc_amt(inc_amt),
    .clr_stb(clr_stb), .clr_idx(clr_idx), .clr_all(clr_all), .snap_stb(snap_stb),
    .mem_a(n_mem), .snap_done(n_done), .sat_any(n_sat), .err_idx(n_err_idx)
  );

  typedef struct {
    logic        iv; logic [4:0] ii; logic [15:0] ia;
    logic        cs; logic [4:0] ci; logic ca; logic sn;
    logic        e_done; logic e_sat; logic [4:0] e_idx; logic [63:0] e_val; logic e_zo;
  } vec_t;

  vec_t tbl [18];
  int n_vec = 0;
  int n_err = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int nz_wide(input int skip);
    int n = 0;
    for (int i = 0; i < 32; i++) if (i != skip && mem_a[i] != 64'd0) n++;
    return n;
  endfunction

  function automatic int nz_narrow(input int skip);
    int n = 0;
    for (int i = 0; i < 32; i++) if (i != skip && n_mem[i] != 20'd0) n++;
    return n;
  endfunction

  function automatic vec_t mk(input logic iv, input logic [4:0] ii, input logic [15:0] ia,
                              input logic cs, input logic [4:0] ci, input logic ca, input logic sn,
                              input logic e_done, input logic [4:0] e_idx,
                              input logic [63:0] e_val, input logic e_zo);
    vec_t v;
    v.iv = iv; v.ii = ii; v.ia = ia; v.cs = cs; v.ci = ci; v.ca = ca; v.sn = sn;
    v.e_done = e_done; v.e_sat = 1'b0; v.e_idx = e_idx; v.e_val = e_val; v.e_zo = e_zo;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic [4:0] ii, input logic [15:0] ia,
                       input logic cs, input logic [4:0] ci, input logic ca, input logic sn);
    @(negedge clk);
    inc_vld = iv; inc_idx = ii; inc_amt = ia;
    clr_stb = cs; clr_idx = ci; clr_all = ca; snap_stb = sn;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 16'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    inc_vld = 0; inc_idx = 0; inc_amt = 0; clr_stb = 0; clr_idx = 0; clr_all = 0; snap_stb = 0;

    // Expectations at vector k reflect requests from vector k-2 and earlier.
    tbl[0]  = mk(0, 0, 0,   0, 0, 0, 1,  0, 0, 0,  1);
    tbl[1]  = mk(0, 0, 0,   0, 0, 0, 0,  0, 0, 0,  1);
    tbl[2]  = mk(0, 0, 0,   0, 0, 0, 0,  1, 0, 0,  1);
    tbl[3]  = mk(0, 0, 0,   0, 0, 0, 0,  0, 0, 0,  1);
    tbl[4]  = mk(1, 3, 5,   0, 0, 0, 0,  0, 0, 0,  1);
    tbl[5]  = mk(1, 3, 5,   0, 0, 0, 1,  0, 3, 0,  1);
    tbl[6]  = mk(1, 3, 5,   0, 0, 0, 0,  0, 3, 0,  1);
    tbl[7]  = mk(1, 3, 5,   0, 0, 0, 1,  1, 3, 10, 1);
    tbl[8]  = mk(0, 0, 0,   0, 0, 0, 1,  0, 3, 10, 1);
    tbl[9]  = mk(0, 0, 0,   0, 0, 0, 0,  1, 3, 20, 1);
    tbl[10] = mk(0, 0, 0,   0, 0, 0, 0,  1, 3, 20, 1);
    tbl[11] = mk(0, 0, 0,   0, 0, 0, 0,  0, 3, 20, 1);
    tbl[12] = mk(1, 9, 100, 0, 0, 0, 0,  0, 3, 20, 1);
    tbl[13] = mk(1, 9, 4,   1, 9, 0, 0,  0, 9, 0,  0);
    tbl[14] = mk(0, 0, 0,   0, 0, 0, 1,  0, 9, 0,  0);
    tbl[15] = mk(0, 0, 0,   0, 0, 0, 0,  0, 9, 0,  0);
    tbl[16] = mk(0, 0, 0,   0, 0, 0, 0,  1, 9, 4,  0);
    tbl[17] = mk(0, 0, 0,   0, 0, 0, 0,  0, 3, 20, 0);

    repeat (3) @(negedge clk);
    cmp("reset_snap_done", {63'd0, snap_done}, 64'd0);
    cmp("reset_sat_any", {63'd0, sat_any}, 64'd0);
    cmp("reset_mem_nonzero", 64'(nz_wide(-1)), 64'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      cmp($sformatf("v%0d_snap_done", k), {63'd0, snap_done}, {63'd0, tbl[k].e_done});
      cmp($sformatf("v%0d_sat_any", k), {63'd0, sat_any}, {63'd0, tbl[k].e_sat});
      cmp($sformatf("v%0d_err_idx", k), {63'd0, err_idx}, 64'd0);
      cmp($sformatf("v%0d_mem[%0d]", k, tbl[k].e_idx), mem_a[tbl[k].e_idx], tbl[k].e_val);
      if (tbl[k].e_zo)
        cmp($sformatf("v%0d_others_nonzero", k), 64'(nz_wide(int'(tbl[k].e_idx))), 64'd0);
      inc_vld = tbl[k].iv; inc_idx = tbl[k].ii; inc_amt = tbl[k].ia;
      clr_stb = tbl[k].cs; clr_idx = tbl[k].ci; clr_all = tbl[k].ca; snap_stb = tbl[k].sn;
    end

    // Narrow bank: reach exactly all-ones (no carry, so no saturation), then add 0.
    repeat (16) drive(1, 8, 16'hFFFF, 0, 0, 0, 0);
    drive(1, 8, 16'd15, 0, 0, 0, 1);
    idle(); idle();
    cmp("exact_max_n_mem8", 64'(n_mem[8]), 64'hFFFFF);
    cmp("exact_max_n_sat", {63'd0, n_sat}, 64'd0);
    cmp("exact_max_n_done", {63'd0, n_done}, 64'd1);
    cmp("exact_max_w_mem8", mem_a[8], 64'd1048575);
    drive(1, 8, 16'd0, 0, 0, 0, 1);
    idle(); idle();
    cmp("max_plus0_n_mem8", 64'(n_mem[8]), 64'hFFFFF);
    cmp("max_plus0_n_sat", {63'd0, n_sat}, 64'd0);

    // Preload idx 7 to all-ones minus 2, then overflow it.
    repeat (16) drive(1, 7, 16'hFFFF, 0, 0, 0, 0);
    drive(1, 7, 16'd13, 0, 0, 0, 1);
    idle(); idle();
    cmp("preload_n_mem7", 64'(n_mem[7]), 64'hFFFFD);
    cmp("preload_n_sat", {63'd0, n_sat}, 64'd0);
    drive(1, 7, 16'd10, 0, 0, 0, 1);
    idle(); idle();
    cmp("sat_n_mem7", 64'(n_mem[7]), 64'hFFFFF);
    cmp("sat_n_sat", {63'd0, n_sat}, 64'd1);
    cmp("sat_w_mem7", mem_a[7], 64'h100007);
    cmp("sat_w_sat", {63'd0, sat_any}, 64'd0);
    drive(1, 7, 16'd0, 0, 0, 0, 1);
    idle(); idle();
    cmp("sat_plus0_n_mem7", 64'(n_mem[7]), 64'hFFFFF);
    cmp("sat_plus0_n_sat", {63'd0, n_sat}, 64'd1);

    // clr_all with a same-cycle increment; mem_a must hold until the next snapshot.
    drive(1, 0, 16'd2, 1, 5'd3, 1, 0);
    idle(); idle();
    cmp("clr_all_mem_stable9", mem_a[9], 64'd4);
    cmp("clr_all_n_sat", {63'd0, n_sat}, 64'd0);
    drive(0, 0, 0, 0, 0, 0, 1);
    idle(); idle();
    cmp("clr_all_w_mem0", mem_a[0], 64'd2);
    cmp("clr_all_w_others", 64'(nz_wide(0)), 64'd0);
    cmp("clr_all_n_mem0", 64'(n_mem[0]), 64'd2);
    cmp("clr_all_n_others", 64'(nz_narrow(0)), 64'd0);
    cmp("clr_all_w_sat", {63'd0, sat_any}, 64'd0);

    // Reset while an increment sits in S1.
    drive(1, 1, 16'd9, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    inc_vld = 0; inc_idx = 0; inc_amt = 0; clr_stb = 0; clr_idx = 0; clr_all = 0; snap_stb = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1);
    idle();
    cmp("rst_done_early", {63'd0, snap_done}, 64'd0);
    idle();
    cmp("rst_done", {63'd0, snap_done}, 64'd1);
    cmp("rst_mem1", mem_a[1], 64'd0);
    cmp("rst_w_all_zero", 64'(nz_wide(-1)), 64'd0);
    cmp("rst_n_all_zero", 64'(nz_narrow(-1)), 64'd0);
    cmp("rst_sat", {63'd0, sat_any}, 64'd0);
    cmp("rst_err_idx", {63'd0, err_idx | n_err_idx}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
